e_muldiv_seq: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO accumulator registers, living in the Execute stage beside the ALU. It extends the fixed-latency HI/LO unit in three ways: operand width is a parameter, multiply latency is a parameter, and divide uses a real iterative restoring divider. It also adds multiply-accumulate ops (madd/maddu/msub/msubu) and a completion pulse. The pipeline stalls on `busy`; exceptions gate new issue through `req`.

---
 rtl/e_muldiv_seq_pkg.sv | 42 ++++
 rtl/e_muldiv_seq_div.sv | 66 ++++++
 rtl/e_muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_e_muldiv_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/e_muldiv_seq_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op codes,
// FSM state encodings and op-class decode helpers.
package e_muldiv_seq_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;
    localparam logic [3:0] OP_MFHI  = 4'd11;
    localparam logic [3:0] OP_MFLO  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Any op that occupies the multiplier path (plain or accumulate).
    function automatic logic is_mul_op(input logic [3:0] o);
        return (o == OP_MULT)  || (o == OP_MULTU) ||
               (o == OP_MADD)  || (o == OP_MADDU) ||
               (o == OP_MSUB)  || (o == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Multiply ops whose operands are treated as two's complement.
    function automatic logic is_signed_mul(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/e_muldiv_seq_div.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit
// per cycle for WIDTH cycles after load. Sign handling lives in the parent.
module e_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Partial remainder shifted by the next dividend bit, and the trial subtraction.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    assign last = active && (cnt == '0);

    // Iteration control: WIDTH steps, the final one flagged by last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Datapath: quotient bits shift in from the bottom as dividend bits shift out.
    always_ff @(posedge clk) begin
        if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (active) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/e_muldiv_seq.sv
// Multi-cycle multiply/divide unit with HI/LO accumulator registers.
// Multiply results are computed at issue and released after MUL_LAT
// busy cycles; divides iterate WIDTH cycles plus one sign-fix cycle.
module e_muldiv_seq
    import e_muldiv_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             req,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_out
);

    localparam int CNT_W = 5;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo;

    logic [3:0]                op_p1;
    logic signed [2*WIDTH-1:0] prod_p1;
    logic [WIDTH-1:0]          rs_p1;
    logic                      neg_q_p1, neg_r_p1, dz_p1;

    logic             can_issue, issue_mul, issue_div, div_signed;
    logic             commit_mul, commit_div;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic             div_last;
    logic [2*WIDTH-1:0] acc, mul_res;

    // Magnitude of v when it is interpreted as signed, otherwise v itself.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Sign- or zero-extension to the full product width.
    function automatic logic [2*WIDTH-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign busy       = (state != S_IDLE);
    assign can_issue  = start && !req && !busy;
    assign issue_mul  = can_issue && is_mul_op(op);
    assign issue_div  = can_issue && is_div_op(op);
    assign div_signed = (op == OP_DIV);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and commit strobes.
    always_comb begin
        state_nx   = state;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue_mul) begin
                    state_nx = S_MUL;
                end else if (issue_div) begin
                    state_nx = S_DIV;
                end
            end
            S_MUL: begin
                if (cnt == '0) begin
                    commit_mul = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            S_DIV: begin
                if (div_last) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                commit_div = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiply latency counter and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= commit_mul || commit_div;
            if (issue_mul) begin
                cnt <= CNT_W'(MUL_LAT - 1);
            end else if ((state == S_MUL) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Issue-time operand capture; the product is formed here, once.
    always_ff @(posedge clk) begin
        if (issue_mul || issue_div) begin
            op_p1    <= op;
            rs_p1    <= rs;
            prod_p1  <= $signed(ext(rs, is_signed_mul(op))) * $signed(ext(rt, is_signed_mul(op)));
            neg_q_p1 <= div_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_r_p1 <= div_signed && rs[WIDTH-1];
            dz_p1    <= (rt == '0);
        end
    end

    e_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .load    (issue_div),
        .dividend(mag(rs, div_signed)),
        .divisor (mag(rt, div_signed)),
        .quo     (div_quo),
        .rem     (div_rem),
        .last    (div_last)
    );

    // Multiply result, optionally accumulated onto HI/LO as they stand at commit.
    always_comb begin
        acc     = {hi, lo};
        mul_res = prod_p1;
        case (op_p1)
            OP_MADD, OP_MADDU: mul_res = acc + prod_p1;
            OP_MSUB, OP_MSUBU: mul_res = acc - prod_p1;
            default:           mul_res = prod_p1;
        endcase
    end

    // HI/LO: multiply/divide commits and mthi/mtlo writes (never in the same cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit_mul) begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
        end else if (commit_div) begin
            if (dz_p1) begin
                hi <= rs_p1;
                lo <= '1;
            end else begin
                hi <= cond_neg(div_rem, neg_r_p1);
                lo <= cond_neg(div_quo, neg_q_p1);
            end
        end else if (can_issue && (op == OP_MTHI)) begin
            hi <= rs;
        end else if (can_issue && (op == OP_MTLO)) begin
            lo <= rs;
        end
    end

    // Read port: HI on mfhi, LO on mflo, zero otherwise.
    always_comb begin
        hilo_out = '0;
        if (op == OP_MFHI) begin
            hilo_out = hi;
        end else if (op == OP_MFLO) begin
            hilo_out = lo;
        end
    end

endmodule

// File: tb/tb_e_muldiv_seq.sv
// Directed bench for e_muldiv_seq: a WIDTH=32/MUL_LAT=5 instance and a
// WIDTH=16/MUL_LAT=1 instance, with hand-computed HI/LO and timing.
module tb_e_muldiv_seq;
    import e_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op, op2;
    logic        start, start2, req;
    logic [31:0] rs, rt;
    logic        busy1, done1, busy2, done2;
    logic [31:0] hilo1;
    logic [15:0] hilo2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e_muldiv_seq #(.WIDTH(32), .MUL_LAT(5)) u_dut32 (
        .clk(clk), .reset(reset), .op(op), .start(start), .req(req),
        .rs(rs), .rt(rt), .busy(busy1), .done(done1), .hilo_out(hilo1)
    );

    e_muldiv_seq #(.WIDTH(16), .MUL_LAT(1)) u_dut16 (
        .clk(clk), .reset(reset), .op(op2), .start(start2), .req(req),
        .rs(rs[15:0]), .rt(rt[15:0]), .busy(busy2), .done(done2), .hilo_out(hilo2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input bit u2);
        return u2 ? busy2 : busy1;
    endfunction

    function automatic logic done_of(input bit u2);
        return u2 ? done2 : done1;
    endfunction

    function automatic logic [31:0] hilo_of(input bit u2);
        return u2 ? {16'h0, hilo2} : hilo1;
    endfunction

    task automatic drive(input bit u2, input logic [3:0] o, input logic s);
        if (u2) begin
            op2    = o;
            start2 = s;
        end else begin
            op    = o;
            start = s;
        end
    endtask

    task automatic read_hilo(input bit u2, output logic [31:0] h, output logic [31:0] l);
        drive(u2, OP_MFHI, 1'b0);
        #1 h = hilo_of(u2);
        drive(u2, OP_MFLO, 1'b0);
        #1 l = hilo_of(u2);
        drive(u2, OP_NONE, 1'b0);
    endtask

    task automatic run_op(input string tag, input bit u2, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [31:0] h, l;
        @(negedge clk);
        rs = a;
        rt = b;
        drive(u2, o, 1'b1);
        @(negedge clk);
        drive(u2, OP_NONE, 1'b0);
        n = 0;
        while (busy_of(u2) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".busy_len"}, 64'(n), 64'(exp_busy));
        chk({tag, ".done"}, 64'(done_of(u2)), 64'd1);
        read_hilo(u2, h, l);
        chk({tag, ".hi"}, 64'(h), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(l), 64'(exp_lo));
        @(negedge clk);
        chk({tag, ".done_off"}, 64'(done_of(u2)), 64'd0);
    endtask

    task automatic reset_mid(input string tag, input bit u2);
        int d;
        logic [31:0] h, l;
        @(negedge clk);
        rs = 32'd100;
        rt = 32'd7;
        drive(u2, OP_DIVU, 1'b1);
        @(negedge clk);
        drive(u2, OP_NONE, 1'b0);
        repeat (9) @(negedge clk);
        chk({tag, ".busy_c10"}, 64'(busy_of(u2)), 64'd1);
        reset = 1'b1;
        #1;
        chk({tag, ".busy_rst"}, 64'(busy_of(u2)), 64'd0);
        read_hilo(u2, h, l);
        chk({tag, ".hi_rst"}, 64'(h), 64'd0);
        chk({tag, ".lo_rst"}, 64'(l), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        d = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_of(u2)) d++;
        end
        chk({tag, ".no_done"}, 64'(d), 64'd0);
        chk({tag, ".idle"}, 64'(busy_of(u2)), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] h, l;
        reset  = 1'b1;
        op     = OP_NONE;
        op2    = OP_NONE;
        start  = 1'b0;
        start2 = 1'b0;
        req    = 1'b0;
        rs     = '0;
        rt     = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy32", 64'(busy1), 64'd0);
        chk("rst.done32", 64'(done1), 64'd0);
        chk("rst.busy16", 64'(busy2), 64'd0);
        reset = 1'b0;
        read_hilo(1'b0, h, l);
        chk("rst.hi", 64'(h), 64'd0);
        chk("rst.lo", 64'(l), 64'd0);

        run_op("mult",   1'b0, OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",  1'b0, OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("divu",   1'b0, OP_DIVU,  32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div",    1'b0, OP_DIV,   32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0",  1'b0, OP_DIVU,  32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
        run_op("div0",   1'b0, OP_DIV,   32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divovf", 1'b0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

        // mthi / mtlo, visible in the following cycle
        @(negedge clk);
        rs = 32'd1;
        drive(1'b0, OP_MTHI, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_NONE, 1'b0);
        read_hilo(1'b0, h, l);
        chk("mthi.hi", 64'(h), 64'd1);
        chk("mthi.lo_kept", 64'(l), 64'h8000_0000);
        @(negedge clk);
        rs = 32'hFFFF_FFFF;
        drive(1'b0, OP_MTLO, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_NONE, 1'b0);
        read_hilo(1'b0, h, l);
        chk("mtlo.lo", 64'(l), 64'hFFFF_FFFF);

        run_op("madd",  1'b0, OP_MADD,  32'd1, 32'd1, 5, 32'd2, 32'd0);
        run_op("msubu", 1'b0, OP_MSUBU, 32'd1, 32'd1, 5, 32'd1, 32'hFFFF_FFFF);

        // req blocks both issue and mthi
        @(negedge clk);
        req = 1'b1;
        rs  = 32'd7;
        rt  = 32'd9;
        drive(1'b0, OP_MULT, 1'b1);
        @(negedge clk);
        chk("req.busy", 64'(busy1), 64'd0);
        drive(1'b0, OP_MTHI, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_NONE, 1'b0);
        req = 1'b0;
        chk("req.busy2", 64'(busy1), 64'd0);
        read_hilo(1'b0, h, l);
        chk("req.hi", 64'(h), 64'd1);
        chk("req.lo", 64'(l), 64'hFFFF_FFFF);

        // mfhi during busy sees old HI; second mult while busy is dropped
        @(negedge clk);
        rs = 32'd2;
        rt = 32'd3;
        drive(1'b0, OP_MULT, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_MFHI, 1'b0);
        chk("busy.c1", 64'(busy1), 64'd1);
        #1 chk("busy.mfhi_old", 64'(hilo1), 64'd1);
        rs = 32'd5;
        rt = 32'd5;
        drive(1'b0, OP_MULT, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_NONE, 1'b0);
        n = 1;
        while (busy1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy.len", 64'(n), 64'd5);
        chk("busy.done", 64'(done1), 64'd1);
        read_hilo(1'b0, h, l);
        chk("busy.hi", 64'(h), 64'd0);
        chk("busy.lo", 64'(l), 64'd6);
        @(negedge clk);
        chk("busy.no_reissue", 64'(busy1), 64'd0);

        reset_mid("rst32", 1'b0);

        run_op("divu16", 1'b1, OP_DIVU, 32'd100, 32'd7, 17, 32'd2, 32'd14);
        run_op("mult16", 1'b1, OP_MULT, 32'h0000_FFFE, 32'd3, 1, 32'h0000_FFFF, 32'h0000_FFFA);
        reset_mid("rst16", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
